// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, condition codes,
// flag bit positions and the issue FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD      = 4'b0000;
  localparam logic [3:0] OP_SUB      = 4'b0001;
  localparam logic [3:0] OP_AND      = 4'b0010;
  localparam logic [3:0] OP_ORR      = 4'b0011;
  localparam logic [3:0] OP_EOR      = 4'b0100;
  localparam logic [3:0] OP_LSL      = 4'b0101;
  localparam logic [3:0] OP_MOV      = 4'b0110;
  localparam logic [3:0] OP_MVN      = 4'b0111;
  localparam logic [3:0] OP_LSR      = 4'b1000;
  localparam logic [3:0] OP_ASR      = 4'b1001;
  localparam logic [3:0] OP_ROR      = 4'b1010;
  localparam logic [3:0] OP_SET_FLAG = 4'b1011;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_t;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition-code evaluator: decides whether an instruction
// with condition i_cond executes given the current {N,Z,C,V} flags.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flag,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;
  assign w_n = i_flag[FLAG_N];
  assign w_z = i_flag[FLAG_Z];
  assign w_c = i_flag[FLAG_C];
  assign w_v = i_flag[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: fetches instructions, reads operands from a 16x32
// register file, drives the external combinational ALU and writes back.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NREG   = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Run,
  output logic              Instr_Req,
  output logic [ADDR_W-1:0] Instr_Addr,
  input  logic              Instr_Valid,
  input  logic [31:0]       Instr_Data,
  output logic [31:0]       Alu_Reg1,
  output logic [31:0]       Alu_Reg2,
  output logic [15:0]       Alu_IV,
  output logic [3:0]        Alu_OpCode,
  output logic [3:0]        Alu_Cond,
  output logic              Alu_S,
  output logic [3:0]        Alu_Flag,
  input  logic [31:0]       Alu_Result,
  input  logic [3:0]        Alu_New_Flag,
  output logic              Retired,
  output logic              Skipped,
  output logic              Illegal,
  input  logic [3:0]        Dbg_Addr,
  output logic [31:0]       Dbg_Data
);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [28:0]       r_instr;
  logic [3:0]        r_flags;
  logic [31:0]       r_regs [NREG];
  logic [31:0]       r_result;
  logic [3:0]        r_new_flag;
  logic [3:0]        r_rd;

  // Instruction bits [22:20] are reserved and deliberately dropped.
  logic w_unused_rsvd;
  assign w_unused_rsvd = ^Instr_Data[22:20];

  logic [3:0]  w_cond, w_op, w_rd, w_rm;
  logic        w_s, w_pass, w_illegal, w_drop, w_we;
  logic [15:0] w_iv;
  assign w_cond    = r_instr[28:25];
  assign w_op      = r_instr[24:21];
  assign w_s       = r_instr[20];
  assign w_rd      = r_instr[19:16];
  assign w_iv      = r_instr[15:0];
  assign w_rm      = w_iv[3:0];
  assign w_illegal = op_is_illegal(w_op);
  // A failed condition wins over an illegal opcode: only Skipped pulses then.
  assign w_drop    = !w_pass || w_illegal;
  assign w_we      = (r_state == ST_WB) && (Alu_OpCode < OP_SET_FLAG);

  alu_cond_eval u_cond_eval (
    .i_cond (w_cond),
    .i_flag (r_flags),
    .o_pass (w_pass)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (Run) w_state_next = ST_FETCH;
      ST_FETCH:  if (Instr_Valid) w_state_next = ST_DECODE;
      ST_DECODE: begin
        if (w_drop) w_state_next = Run ? ST_FETCH : ST_IDLE;
        else        w_state_next = ST_EXEC;
      end
      ST_EXEC:   w_state_next = ST_WB;
      ST_WB:     w_state_next = Run ? ST_FETCH : ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_flags    <= '0;
      r_result   <= '0;
      r_new_flag <= '0;
      r_rd       <= '0;
      Alu_Reg1   <= '0;
      Alu_Reg2   <= '0;
      Alu_IV     <= '0;
      Alu_OpCode <= '0;
      Alu_Cond   <= '0;
      Alu_S      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_FETCH && Instr_Valid)
        r_instr <= {Instr_Data[31:23], Instr_Data[19:0]};
      if (r_state == ST_DECODE) begin
        Alu_Reg1   <= r_regs[w_rd];
        Alu_Reg2   <= r_regs[w_rm];
        Alu_IV     <= w_iv;
        Alu_OpCode <= w_op;
        Alu_Cond   <= w_cond;
        Alu_S      <= w_s;
        r_rd       <= w_rd;
      end
      if (r_state == ST_EXEC) begin
        r_result   <= Alu_Result;
        r_new_flag <= Alu_New_Flag;
      end
      if (r_state == ST_WB && (Alu_S || Alu_OpCode == OP_SET_FLAG))
        r_flags <= r_new_flag;
      if ((r_state == ST_DECODE && w_drop) || r_state == ST_WB)
        r_pc <= r_pc + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_regfile
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
        r_regs[gi] <= '0;
      else if (w_we && r_rd == 4'(gi))
        r_regs[gi] <= r_result;
    end
  end

  assign Instr_Req  = (r_state == ST_FETCH);
  assign Instr_Addr = r_pc;
  assign Alu_Flag   = r_flags;
  assign Retired    = (r_state == ST_WB);
  assign Skipped    = (r_state == ST_DECODE) && !w_pass;
  assign Illegal    = (r_state == ST_DECODE) && w_pass && w_illegal;
  assign Dbg_Data   = r_regs[Dbg_Addr];

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential issue controller driving the combinational MASTER_ALU from the instruction side. It fetches 32-bit instructions over a valid/request handshake, decodes the Cond/OpCode/S/Rd/IV fields and reads operands from an internal 16x32 register file. It evaluates Cond against the architectural NZCV flags, presents operands to the ALU, then writes back Result and New_Flag. It sits between instruction memory and the ALU.

Parameters:
ADDR_W, 8, instruction address (PC) width
NREG, 16, register file depth (fixed at 16; 4-bit register fields)

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Run  in  1  level; 1 = fetch/execute, 0 = stop at next FETCH boundary
Instr_Req  out  1  fetch request, held until accepted
Instr_Addr  out  ADDR_W  fetch address (PC)
Instr_Valid  in  1  instruction data valid; accepted when Instr_Req=1
Instr_Data  in  32  instruction word
Alu_Reg1  out  32  register file value of Rd
Alu_Reg2  out  32  register file value of Rm (IV[3:0])
Alu_IV  out  16  immediate field
Alu_OpCode  out  4  opcode
Alu_Cond  out  4  condition field (informational)
Alu_S  out  1  set-flags bit
Alu_Flag  out  4  current flags {N,Z,C,V}
Alu_Result  in  32  ALU result, combinational from Alu_* outputs
Alu_New_Flag  in  4  ALU flag result
Retired  out  1  one-cycle pulse per executed instruction
Skipped  out  1  one-cycle pulse per condition-failed instruction
Illegal  out  1  one-cycle pulse on opcode 1100-1111
Dbg_Addr  in  4  debug register read select
Dbg_Data  out  32  combinational register file read

Behaviour:
- Reset, asynchronous: state IDLE, PC=0, flags=0000, all registers=0. Instr_Req, Retired, Skipped and Illegal are 0. Alu_* operand latches are 0.
- Instruction format: [31:28] Cond, [27:24] OpCode, [23] S, [22:20] reserved (ignored), [19:16] Rd, [15:0] IV. Rm=IV[3:0].
- States: IDLE, FETCH, DECODE, EXEC, WB.
- IDLE -> FETCH when Run=1.
- FETCH: Instr_Req=1, Instr_Addr=PC. On Instr_Valid=1, latch the instruction and go to DECODE. Instr_Valid is ignored while Instr_Req=0.
- DECODE: latch Rd/Rm register values and the fields into the Alu_* registers, then evaluate Cond on the current flags:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0
- Condition false: pulse Skipped, PC+1, go to FETCH (or IDLE if Run=0). No register or flag change.
- Opcode 1100-1111: pulse Illegal, treat as NOP with no writes, PC+1.
- EXEC: Alu_* stable for one full cycle; sample Alu_Result and Alu_New_Flag at the end of EXEC.
- WB:
  - Write Rd=Result for opcodes 0000-1010.
  - Opcode 1011 (SET_FLAG) writes no register.
  - Flags <= New_Flag if S=1 or opcode=1011.
  - Pulse Retired, PC+1, go to FETCH if Run=1, else IDLE.
- Latency: fetch-accept to Retired is 3 cycles (DECODE, EXEC, WB). Minimum 4 cycles per instruction with zero-wait memory.
- PC wraps from 2^ADDR_W-1 to 0 silently.
- Run=0 mid-instruction completes the current instruction, then enters IDLE. An outstanding FETCH request is held until accepted.
- Writing Rd and using it in the next instruction needs no forwarding: the write completes in WB before the next DECODE.
- Dbg_Data reads the register file combinationally; the WB-cycle write is visible the cycle after.
- Reset mid-operation aborts immediately. Instr_Req drops asynchronously.

Decomposition:
- Shared package alu_pkg holds opcode constants (OP_ADD=0000 ... OP_SET_FLAG=1011), condition constants (COND_EQ ... COND_NV), flag bit indices (N=3, Z=2, C=1, V=0) and the FSM state enum.
- One sub-module, alu_cond_eval: purely combinational Cond x Flag -> pass. Unit-tested separately.

Test Plan:
- Reset then Run=1, memory returns 0xE6000005 at PC 0 (AL MOV-immediate to R0, IV=5) -> Instr_Addr=0 with Instr_Req, Alu_OpCode=0110 and Alu_IV=0x0005 in EXEC, Retired 3 cycles after accept, Instr_Addr=1 next.
- R1=3, R2=3, SET_FLAG 0xEB010002 (R1 vs R2), then EQ ADD 0x00810002 (S=1) -> flags from ALU latched (Z=1), ADD retires, R1 updated, flags updated.
- Flags Z=0, instruction 0x00010002 (EQ) -> Skipped pulse, no Retired, R1 unchanged via Dbg_Data, PC+1.
- Opcode 1100 word 0xEC000000 -> Illegal pulse, no register or flag write, PC advances.
- Instr_Valid withheld 5 cycles -> Instr_Req stays high, no state advance; Run dropped during EXEC -> instruction retires, then IDLE with Instr_Req=0.
- PC=0xFF (ADDR_W=8) retires -> next Instr_Addr=0x00. Rst_n asserted in EXEC -> all outputs reset immediately.
